// File: rtl/chip8_fb_streamer_if.sv
// rtl/chip8_fb_streamer_if.sv - byte stream handshake bundle for chip8_fb_streamer
interface chip8_fb_streamer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_first;
   logic       out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_first,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_first,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/chip8_fb_streamer.sv
// rtl/chip8_fb_streamer.sv - snapshots a 64x32 CHIP-8 framebuffer and streams it as 256 bytes
module chip8_fb_streamer #(
   parameter logic [15:0] FRAME_DIV = 16'd0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2047:0]              display,
   input  logic                       start,
   chip8_fb_streamer_if.master        out_if,
   output logic                       busy,
   output logic                       frame_done,
   output logic [7:0]                 overrun_count
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   // FRAME_DIV = 0 wraps this to all-ones, but tick is gated off in that case
   localparam logic [15:0] DIV_M1 = FRAME_DIV - 16'd1;

   state_t        state_q;
   logic [15:0]   tick_cnt_q;
   logic [15:0]   tick_cnt_d;
   logic [2047:0] shadow_q;
   logic [7:0]    k_q;
   logic [7:0]    k_d;
   logic [7:0]    overrun_q;
   logic [7:0]    overrun_d;
   logic [7:0]    out_data_q;
   logic          out_valid_q;
   logic          out_first_q;
   logic          out_last_q;
   logic          busy_q;
   logic          frame_done_q;
   logic [7:0]    next_byte;
   logic          tick;
   logic          trigger;
   logic          xfer;

   // Trigger generation, overrun saturation and the byte that follows the current one
   always_comb begin
      tick       = (FRAME_DIV != 16'd0) && (tick_cnt_q == DIV_M1);
      trigger    = start | tick;
      tick_cnt_d = ((FRAME_DIV == 16'd0) || tick) ? 16'd0 : tick_cnt_q + 16'd1;
      xfer       = out_valid_q & out_if.out_ready;
      overrun_d  = overrun_q;
      if ((state_q == SEND) && trigger && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end
      k_d        = k_q + 8'd1;
      next_byte  = shadow_q[{k_d, 3'b000} +: 8];
   end

   // Two-state frame FSM with all stream outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         tick_cnt_q   <= '0;
         shadow_q     <= '0;
         k_q          <= '0;
         overrun_q    <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_first_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         overrun_q    <= overrun_d;
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  shadow_q    <= display;
                  k_q         <= 8'd0;
                  out_data_q  <= display[7:0];
                  out_valid_q <= 1'b1;
                  out_first_q <= 1'b1;
                  out_last_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (k_q == 8'hFF) begin
                     k_q          <= 8'd0;
                     out_data_q   <= 8'h00;
                     out_valid_q  <= 1'b0;
                     out_first_q  <= 1'b0;
                     out_last_q   <= 1'b0;
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                     state_q      <= IDLE;
                  end else begin
                     k_q         <= k_d;
                     out_data_q  <= next_byte;
                     out_first_q <= 1'b0;
                     out_last_q  <= (k_d == 8'hFF);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_first = out_first_q;
   assign out_if.out_last  = out_last_q;
   assign busy             = busy_q;
   assign frame_done       = frame_done_q;
   assign overrun_count    = overrun_q;

endmodule

// File: tb/tb_chip8_fb_streamer.sv
// tb/tb_chip8_fb_streamer.sv - model-checked bench for chip8_fb_streamer at FRAME_DIV 0, 300 and 100
module tb_chip8_fb_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [2047:0]   display;
   logic [2:0]      start;
   logic [2:0]      ready;
   logic [2:0]      busy;
   logic [2:0]      fdone;
   logic [2:0][7:0] ovr;
   logic [2:0][7:0] odata;
   logic [2:0]      ovalid;
   logic [2:0]      ofirst;
   logic [2:0]      olast;

   chip8_fb_streamer_if if0 ();
   chip8_fb_streamer_if if1 ();
   chip8_fb_streamer_if if2 ();

   chip8_fb_streamer #(.FRAME_DIV(16'd0)) dut0 (
      .clk(clk), .reset(reset), .display(display), .start(start[0]), .out_if(if0.master),
      .busy(busy[0]), .frame_done(fdone[0]), .overrun_count(ovr[0]));
   chip8_fb_streamer #(.FRAME_DIV(16'd300)) dut1 (
      .clk(clk), .reset(reset), .display(display), .start(start[1]), .out_if(if1.master),
      .busy(busy[1]), .frame_done(fdone[1]), .overrun_count(ovr[1]));
   chip8_fb_streamer #(.FRAME_DIV(16'd100)) dut2 (
      .clk(clk), .reset(reset), .display(display), .start(start[2]), .out_if(if2.master),
      .busy(busy[2]), .frame_done(fdone[2]), .overrun_count(ovr[2]));

   assign if0.out_ready = ready[0];
   assign if1.out_ready = ready[1];
   assign if2.out_ready = ready[2];
   assign odata[0] = if0.out_data;  assign ovalid[0] = if0.out_valid;
   assign ofirst[0] = if0.out_first; assign olast[0] = if0.out_last;
   assign odata[1] = if1.out_data;  assign ovalid[1] = if1.out_valid;
   assign ofirst[1] = if1.out_first; assign olast[1] = if1.out_last;
   assign odata[2] = if2.out_data;  assign ovalid[2] = if2.out_valid;
   assign ofirst[2] = if2.out_first; assign olast[2] = if2.out_last;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a frame is a list of 256 bytes captured at trigger and consumed one per accept
   int         div_of [3] = '{0, 300, 100};
   logic [7:0] m_frame [3][256];
   int         m_pos [3];
   int         m_ovr [3];
   int         m_cyc [3];
   bit         m_busy [3];
   bit         m_done [3];
   bit         m_tick;
   bit         m_trig;

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_pos[i] = 0; m_ovr[i] = 0; m_cyc[i] = 0; m_busy[i] = 0; m_done[i] = 0;
      end
      forever begin
         @(posedge clk or posedge reset);
         for (int i = 0; i < 3; i++) begin
            if (reset) begin
               m_busy[i] = 0; m_pos[i] = 0; m_ovr[i] = 0; m_done[i] = 0; m_cyc[i] = 0;
            end else begin
               m_tick = (div_of[i] != 0) ? ((m_cyc[i] % div_of[i]) == div_of[i] - 1) : 1'b0;
               m_trig = start[i] | m_tick;
               m_cyc[i]++;
               m_done[i] = 0;
               if (!m_busy[i]) begin
                  if (m_trig) begin
                     for (int b = 0; b < 256; b++) m_frame[i][b] = display[b*8 +: 8];
                     m_pos[i]  = 0;
                     m_busy[i] = 1;
                  end
               end else begin
                  if (m_trig && m_ovr[i] < 255) m_ovr[i]++;
                  if (ready[i]) begin
                     m_pos[i]++;
                     if (m_pos[i] == 256) begin
                        m_busy[i] = 0;
                        m_done[i] = 1;
                     end
                  end
               end
            end
         end
      end
   end

   // Compare every DUT against the model on each falling edge
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d valid", i), 32'(ovalid[i]), 32'(m_busy[i]));
            check($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(m_busy[i]));
            check($sformatf("dut%0d frame_done", i), 32'(fdone[i]), 32'(m_done[i]));
            check($sformatf("dut%0d overrun", i), 32'(ovr[i]), 32'(m_ovr[i]));
            if (m_busy[i]) begin
               check($sformatf("dut%0d data", i), 32'(odata[i]), 32'(m_frame[i][m_pos[i]]));
               check($sformatf("dut%0d first", i), 32'(ofirst[i]), 32'(m_pos[i] == 0));
               check($sformatf("dut%0d last", i), 32'(olast[i]), 32'(m_pos[i] == 255));
            end else begin
               check($sformatf("dut%0d first idle", i), 32'(ofirst[i]), 32'd0);
               check($sformatf("dut%0d last idle", i), 32'(olast[i]), 32'd0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [2047:0] pat(input bit inv);
      logic [2047:0] r;
      for (int b = 0; b < 256; b++) r[b*8 +: 8] = inv ? ~8'(b) : 8'(b);
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(3);
      reset = 1'b0;
   endtask

   logic [7:0] got [$];
   int         n;
   int         errs;

   initial begin
      reset   = 1'b1;
      start   = 3'b000;
      ready   = 3'b111;
      display = pat(0);

      // Reset state
      step(2);
      check("rst valid", 32'(ovalid[0]), 32'd0);
      check("rst busy", 32'(busy[0]), 32'd0);
      check("rst data", 32'(odata[0]), 32'h00);
      check("rst overrun", 32'(ovr[0]), 32'd0);
      check("rst first/last/done", 32'({ofirst[0], olast[0], fdone[0]}), 32'd0);
      step(1);
      reset = 1'b0;

      // Plain frame with sink always ready
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      check("s1 valid after trigger", 32'(ovalid[0]), 32'd1);
      check("s1 byte0", 32'(odata[0]), 32'h00);
      check("s1 first", 32'(ofirst[0]), 32'd1);
      step(255);
      check("s1 byte255", 32'(odata[0]), 32'hFF);
      check("s1 last", 32'(olast[0]), 32'd1);
      step(1);
      check("s1 frame_done", 32'(fdone[0]), 32'd1);
      check("s1 valid low", 32'(ovalid[0]), 32'd0);
      step(1);
      check("s1 frame_done one cycle", 32'(fdone[0]), 32'd0);

      // Random backpressure, display overwritten mid-frame
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      got.delete();
      n = 0;
      while (got.size() < 256 && n < 3000) begin
         ready[0] = 1'($urandom_range(0, 1));
         if (ovalid[0] && odata[0] == 8'd10) display = '1;
         if (ovalid[0] && ready[0]) got.push_back(odata[0]);
         step(1);
         n++;
      end
      ready[0] = 1'b1;
      check("s2 byte count", 32'(got.size()), 32'd256);
      errs = 0;
      for (int b = 0; b < got.size(); b++) if (got[b] != 8'(b)) errs++;
      check("s2 sequence errors", 32'(errs), 32'd0);
      display = pat(0);
      step(2);

      // start held high: back-to-back frames
      do_reset();
      start[0] = 1'b1; step(1);
      check("s3 frame1 first", 32'(ofirst[0]), 32'd1);
      step(256);
      check("s3 gap done", 32'(fdone[0]), 32'd1);
      check("s3 gap idle", 32'(ovalid[0]), 32'd0);
      step(1);
      check("s3 frame2 first", 32'(ofirst[0]), 32'd1);
      step(256);
      check("s3 frame2 done", 32'(fdone[0]), 32'd1);
      check("s3 overrun", 32'(ovr[0]), 32'd255);
      start[0] = 1'b0;
      step(1);
      check("s3 stays idle", 32'(ovalid[0]), 32'd0);

      // Auto-trigger every 300 clocks
      do_reset();
      n = 0;
      while (!ovalid[1] && n < 400) begin step(1); n++; end
      check("s4 first frame latency", 32'(n), 32'd300);
      while (ovalid[1] && n < 1000) begin step(1); n++; end
      while (!ovalid[1] && n < 1000) begin step(1); n++; end
      check("s4 second frame latency", 32'(n), 32'd600);
      check("s4 overrun", 32'(ovr[1]), 32'd0);

      // Reset in the middle of a frame
      do_reset();
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      step(100);
      check("s5 byte100", 32'(odata[0]), 32'd100);
      reset = 1'b1;
      #1;
      check("s5 valid cleared", 32'(ovalid[0]), 32'd0);
      check("s5 busy cleared", 32'(busy[0]), 32'd0);
      step(2);
      reset = 1'b0;
      display = pat(1);
      errs = 0;
      for (int c = 0; c < 5; c++) begin
         step(1);
         if (fdone[0] || ovalid[0]) errs++;
      end
      check("s5 quiet after reset", 32'(errs), 32'd0);
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      check("s5 fresh byte0", 32'(odata[0]), 32'hFF);
      check("s5 fresh first", 32'(ofirst[0]), 32'd1);
      step(1);
      check("s5 fresh byte1", 32'(odata[0]), 32'hFE);
      step(300);

      // Stalled sink with auto-trigger every 100 clocks
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      start[2] = 1'b1; ready[2] = 1'b0;
      step(1);
      start[2] = 1'b0;
      step(1000);
      check("s6 overrun", 32'(ovr[2]), 32'd10);
      check("s6 held byte0", 32'(odata[2]), 32'hFF);
      check("s6 still valid", 32'(ovalid[2]), 32'd1);
      ready[2] = 1'b1;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/chip8_fb_streamer.md
CHIP8_FB_STREAMER -- requirements
Module: chip8_fb_streamer

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 16'd0, clk cycles between automatic frame triggers; 0 disables auto-trigger.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port display  input  2048  live framebuffer, one bit per pixel, 1 = lit.
REQ-005 SHALL have port start  input  1  request to stream one frame; sampled only in IDLE.
REQ-006 SHALL have port out_data  output  8  current framebuffer byte.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-008 SHALL have port out_ready  input  1  sink accepts out_data this cycle.
REQ-009 SHALL have port out_first  output  1  high with byte 0 of a frame.
REQ-010 SHALL have port out_last  output  1  high with byte 255 of a frame.
REQ-011 SHALL have port busy  output  1  high while in SEND.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after byte 255 is accepted.
REQ-013 SHALL have port overrun_count  output  8  saturating count of triggers dropped while busy.

Function
REQ-014 SHALL implement FSM states IDLE and SEND only.
REQ-015 SHALL define trigger = start OR tick, where tick is high for one cycle when the free-running tick counter equals FRAME_DIV-1 (never when FRAME_DIV = 0).
REQ-016 Tick counter SHALL count 0..FRAME_DIV-1, wrap to 0, and run in every state from reset.
REQ-017 In IDLE with trigger high at edge E, SHALL copy display into a 2048-bit shadow register, clear byte index to 0, and enter SEND at E.
REQ-018 SHALL assert out_valid in the cycle after E: one-cycle trigger-to-valid latency.
REQ-019 SHALL drive out_data = shadow[8k+7:8k] for byte index k (0..255); bit 0 of the byte = shadow[8k].
REQ-020 Changes on display after E SHALL NOT affect the frame in progress.
REQ-021 SHALL transfer a byte on an edge where out_valid and out_ready are both high; out_data, out_first and out_last SHALL stay stable while out_valid is high and out_ready is low.
REQ-022 After a transfer with k < 255, SHALL increment k and keep out_valid high (no bubble); out_ready low stalls indefinitely.
REQ-023 out_first SHALL equal out_valid AND (k == 0); out_last SHALL equal out_valid AND (k == 255).
REQ-024 After the k = 255 transfer, SHALL return to IDLE, deassert out_valid, and pulse frame_done high for exactly the next cycle.
REQ-025 A trigger in SEND, or in the cycle the final transfer occurs, SHALL be dropped and SHALL increment overrun_count, saturating at 255.
REQ-026 start and tick high together SHALL count as one trigger.
REQ-027 busy SHALL be high exactly when state = SEND; out_valid SHALL equal busy.
REQ-028 A trigger in the IDLE cycle that frame_done is high SHALL start a new frame normally.

Reset
REQ-029 While reset is high, SHALL hold state IDLE, k = 0, tick counter = 0, shadow = 0, overrun_count = 0, and out_valid, out_first, out_last, busy, frame_done = 0, out_data = 8'h00.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done; after reset release, SHALL wait in IDLE for a new trigger.

Verification
REQ-031 FRAME_DIV=0, display = pattern with byte k = k[7:0], start pulse, out_ready=1 -> 256 bytes 0x00..0xFF on consecutive cycles, out_first with 0x00, out_last with 0xFF, frame_done one cycle later.
REQ-032 Same frame, out_ready toggled randomly, display changed to all-ones at byte 10 -> bytes unchanged and stable during stalls, sequence identical to REQ-031.
REQ-033 start held high continuously -> back-to-back frames separated by exactly one IDLE cycle, overrun_count = 255 after the second frame.
REQ-034 FRAME_DIV=300, out_ready=1, start=0 -> frame begins one cycle after every 300th clock; overrun_count stays 0.
REQ-035 Reset asserted at byte 100 -> out_valid=0 and busy=0 immediately, no frame_done; next start streams from byte 0 of a fresh snapshot.
REQ-036 FRAME_DIV=100, out_ready=0 for 1000 cycles after start -> out_data stays at byte 0, overrun_count = 10.
